// File: rtl/osr_controller_pkg.sv
// Shared types for the OSR sequencer: FSM states, the SHIFTCTRL view and count decoding.
package osr_controller_pkg;

  localparam int OSR_FULL_COUNT = 32;

  typedef enum logic [1:0] {
    IDLE,
    OUT_WAIT,
    PULL_WAIT
  } osr_ctrl_state_t;

  typedef struct packed {
    logic       autopull_en;
    logic [4:0] pull_thresh;
  } osr_cfg_t;

  // 5-bit instruction/config counts encode 32 as 0.
  function automatic logic [5:0] decode_count(input logic [4:0] v);
    return (v == 5'd0) ? 6'd32 : {1'b0, v};
  endfunction

endpackage

// File: rtl/osr_controller.sv
// OSR sequencer: owns the shift count, arbitrates MOV/PULL/OUT/autopull and stalls the core
// when the output shift register cannot serve the current instruction.
module osr_controller
  import osr_controller_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_req,
  input  logic [4:0]        out_bits,
  input  logic              pull_req,
  input  logic              pull_block,
  input  logic              pull_ifempty,
  input  logic              mov_req,
  input  logic [DATA_W-1:0] mov_data,
  input  logic [DATA_W-1:0] x_value,
  input  logic              autopull_en,
  input  logic [4:0]        pull_thresh,
  input  logic              tx_empty,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_pop,
  output logic              osr_load,
  output logic [DATA_W-1:0] osr_data_in,
  output logic              shift_en,
  output logic [CNT_W-1:0]  shift_count,
  output logic              stall,
  output logic              done,
  output logic [CNT_W-1:0]  osr_count
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OSR_FULL_COUNT);
  localparam logic [CNT_W:0]   FULL_EXT = (CNT_W+1)'(OSR_FULL_COUNT);

  osr_ctrl_state_t  r_state, w_state_next;
  logic [CNT_W-1:0] r_count, w_count_next;
  osr_cfg_t         w_cfg;
  logic [CNT_W-1:0] w_thr, w_n, w_sat;
  logic [CNT_W:0]   w_sum;
  logic             w_full, w_abandon;

  assign w_cfg   = '{autopull_en: autopull_en, pull_thresh: pull_thresh};
  assign w_thr   = CNT_W'(decode_count(w_cfg.pull_thresh));
  assign w_n     = CNT_W'(decode_count(out_bits));
  assign w_full  = (r_count >= w_thr);
  assign w_sum   = {1'b0, r_count} + {1'b0, w_n};
  assign w_sat   = (w_sum > FULL_EXT) ? FULL_CNT : w_sum[CNT_W-1:0];
  // A WAIT state whose request has been withdrawn just unwinds.
  assign w_abandon = ((r_state == OUT_WAIT) && !out_req) ||
                     ((r_state == PULL_WAIT) && !pull_req);
  assign osr_count = r_count;

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    tx_pop       = 1'b0;
    osr_load     = 1'b0;
    osr_data_in  = '0;
    shift_en     = 1'b0;
    shift_count  = '0;
    stall        = 1'b0;
    done         = 1'b0;
    if (rst) begin
      w_state_next = IDLE;
    end else if (w_abandon) begin
      w_state_next = IDLE;
    end else if (mov_req) begin
      osr_load     = 1'b1;
      osr_data_in  = mov_data;
      w_count_next = '0;
      done         = 1'b1;
      w_state_next = IDLE;
    end else if (pull_req) begin
      if (pull_ifempty && !w_full) begin
        done         = 1'b1;
        w_state_next = IDLE;
      end else if (!tx_empty) begin
        tx_pop       = 1'b1;
        osr_load     = 1'b1;
        osr_data_in  = tx_data;
        w_count_next = '0;
        done         = 1'b1;
        w_state_next = IDLE;
      end else if (pull_block) begin
        stall        = 1'b1;
        w_state_next = PULL_WAIT;
      end else begin
        osr_load     = 1'b1;
        osr_data_in  = x_value;
        w_count_next = '0;
        done         = 1'b1;
        w_state_next = IDLE;
      end
    end else if (out_req) begin
      if (w_cfg.autopull_en && w_full) begin
        stall = 1'b1;
        if (!tx_empty) begin
          // Refill now; the shift itself is served on the following cycle.
          tx_pop       = 1'b1;
          osr_load     = 1'b1;
          osr_data_in  = tx_data;
          w_count_next = '0;
        end else begin
          w_state_next = OUT_WAIT;
        end
      end else begin
        shift_en     = 1'b1;
        shift_count  = w_n;
        w_count_next = w_sat;
        done         = 1'b1;
        w_state_next = IDLE;
      end
    end else if (w_cfg.autopull_en && w_full && !tx_empty) begin
      tx_pop       = 1'b1;
      osr_load     = 1'b1;
      osr_data_in  = tx_data;
      w_count_next = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= FULL_CNT;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
    end
  end

endmodule
